// File: rtl/param_axon_scheduler_pkg.sv
// ============================================================================
// Module : ranc_pkg
// Brief  : Shared defaults and packet/slot helper functions for the axon scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ranc_pkg;

  localparam int DEF_NUM_AXONS = 256;
  localparam int DEF_NUM_SLOTS = 16;

  // Delay field sits above the axon field; the caller supplies the axon width.
  function automatic int unsigned pkt_delay(input logic [31:0] pkt, input int unsigned axon_w);
    return pkt >> axon_w;
  endfunction

  function automatic int unsigned pkt_axon(input logic [31:0] pkt, input int unsigned axon_w);
    return pkt & ((32'd1 << axon_w) - 32'd1);
  endfunction

  // Both operands are below num_slots, so one conditional subtract replaces a modulo.
  function automatic int unsigned wrap_add(input int unsigned ptr, input int unsigned inc,
                                           input int unsigned num_slots);
    int unsigned sum;
    sum = ptr + inc;
    return (sum >= num_slots) ? (sum - num_slots) : sum;
  endfunction

endpackage

`default_nettype wire

// File: rtl/param_axon_scheduler_if.sv
// ============================================================================
// Module : param_axon_scheduler_if
// Brief  : Router-side packet write port and neuron-grid spike delivery bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface param_axon_scheduler_if
  import ranc_pkg::*;
#(
  parameter int NUM_AXONS = DEF_NUM_AXONS,
  parameter int NUM_SLOTS = DEF_NUM_SLOTS
);
  localparam int AXON_W  = $clog2(NUM_AXONS);
  localparam int DELAY_W = $clog2(NUM_SLOTS);
  localparam int PKT_W   = DELAY_W + AXON_W;

  logic                 wen;
  logic [PKT_W-1:0]     packet;
  logic [NUM_AXONS-1:0] axon_spikes;
  logic                 spikes_valid;

  modport master (output wen, output packet, input axon_spikes, input spikes_valid);
  modport slave  (input wen, input packet, output axon_spikes, output spikes_valid);

endinterface

`default_nettype wire

// File: rtl/param_axon_scheduler_slot_row.sv
// ============================================================================
// Module : sched_slot_row
// Brief  : One delay slot of axon bits; a set in the same cycle as a clear wins.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sched_slot_row
  import ranc_pkg::*;
#(
  parameter  int NUM_AXONS = DEF_NUM_AXONS,
  localparam int AXON_W    = $clog2(NUM_AXONS)
) (
  input  wire logic                 clk,
  input  wire logic                 reset_n,
  input  wire logic                 set_en,
  input  wire logic [AXON_W-1:0]    set_idx,
  input  wire logic                 clr_en,
  output logic      [NUM_AXONS-1:0] row
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
    end else begin
      if (clr_en) row <= '0;
      if (set_en) row[set_idx] <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/param_axon_scheduler.sv
// ============================================================================
// Module : param_axon_scheduler
// Brief  : Circular delay-slot spike scheduler; optional duplicate counter via
//          SCHED_DUP_COUNT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module param_axon_scheduler
  import ranc_pkg::*;
#(
  parameter  int NUM_AXONS = DEF_NUM_AXONS,
  parameter  int NUM_SLOTS = DEF_NUM_SLOTS,
  localparam int AXON_W    = $clog2(NUM_AXONS),
  localparam int DELAY_W   = $clog2(NUM_SLOTS)
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  input  wire logic               tick,
  input  wire logic               error_clr,
  param_axon_scheduler_if.slave   bus,
  output logic                    error,
  output logic [DELAY_W-1:0]      rd_ptr
`ifdef SCHED_DUP_COUNT_EN
  ,
  output logic [15:0]             dup_count
`endif
);

  localparam int                PKT_W     = DELAY_W + AXON_W;
  localparam logic [AXON_W:0]   AXON_LIM  = (AXON_W+1)'(NUM_AXONS);
  localparam logic [DELAY_W:0]  DELAY_LIM = (DELAY_W+1)'(NUM_SLOTS);
  localparam logic [DELAY_W-1:0] LAST_SLOT = DELAY_W'(NUM_SLOTS - 1);

  logic [PKT_W-1:0]     pkt;
  logic [DELAY_W-1:0]   pkt_dly;
  logic [AXON_W-1:0]    pkt_ax;
  logic                 pkt_ok;
  logic                 wr_legal;
  logic                 wr_illegal;
  logic [DELAY_W-1:0]   next_ptr;
  logic [DELAY_W-1:0]   base_ptr;
  logic [DELAY_W-1:0]   target;
  logic [NUM_AXONS-1:0] rows [NUM_SLOTS];
  logic [NUM_AXONS-1:0] cur_row;
  logic [NUM_AXONS-1:0] spikes_r;
  logic                 valid_r;

  assign pkt     = bus.packet;
  assign pkt_dly = DELAY_W'(pkt_delay(32'(pkt), AXON_W));
  assign pkt_ax  = AXON_W'(pkt_axon(32'(pkt), AXON_W));
  assign pkt_ok  = ({1'b0, pkt_ax} < AXON_LIM) && ({1'b0, pkt_dly} < DELAY_LIM);

  assign wr_legal   = bus.wen && pkt_ok;
  assign wr_illegal = bus.wen && !pkt_ok;

  // A write coinciding with a tick is timed from the slot after the one being delivered.
  assign next_ptr = (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
  assign base_ptr = tick ? next_ptr : rd_ptr;
  assign target   = DELAY_W'(wrap_add(32'(base_ptr), 32'(pkt_dly), NUM_SLOTS));

  generate
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      sched_slot_row #(.NUM_AXONS(NUM_AXONS)) u_row (
        .clk     (clk),
        .reset_n (reset_n),
        .set_en  (wr_legal && (target == DELAY_W'(i))),
        .set_idx (pkt_ax),
        .clr_en  (tick && (rd_ptr == DELAY_W'(i))),
        .row     (rows[i])
      );
    end
  endgenerate

  always_comb begin
    cur_row = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (rd_ptr == DELAY_W'(i)) cur_row = rows[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spikes_r <= '0;
      valid_r  <= 1'b0;
      rd_ptr   <= '0;
      error    <= 1'b0;
    end else begin
      valid_r <= tick;
      if (tick) begin
        spikes_r <= cur_row;
        rd_ptr   <= next_ptr;
      end
      if (wr_illegal)     error <= 1'b1;
      else if (error_clr) error <= 1'b0;
    end
  end

  assign bus.axon_spikes  = spikes_r;
  assign bus.spikes_valid = valid_r;

`ifdef SCHED_DUP_COUNT_EN
  logic [NUM_AXONS-1:0] tgt_row;

  // Bit state before this edge, so a set-wins write onto the cleared slot still counts.
  always_comb begin
    tgt_row = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (target == DELAY_W'(i)) tgt_row = rows[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dup_count <= '0;
    end else if (error_clr) begin
      dup_count <= '0;
    end else if (wr_legal && tgt_row[pkt_ax] && (dup_count != 16'hFFFF)) begin
      dup_count <= dup_count + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_param_axon_scheduler.sv
// ============================================================================
// Module : tb_param_axon_scheduler
// Brief  : Directed plus random stimulus against a due-tick reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_param_axon_scheduler;

  localparam int NA = 200;
  localparam int NS = 10;
  localparam int AW = $clog2(NA);
  localparam int DW = $clog2(NS);

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          tick = 1'b0;
  logic          error_clr = 1'b0;
  logic          error;
  logic [DW-1:0] rd_ptr;
`ifdef SCHED_DUP_COUNT_EN
  logic [15:0]   dup_count;
`endif

  param_axon_scheduler_if #(.NUM_AXONS(NA), .NUM_SLOTS(NS)) bus ();

  param_axon_scheduler #(.NUM_AXONS(NA), .NUM_SLOTS(NS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .error_clr (error_clr),
    .bus       (bus),
    .error     (error),
    .rd_ptr    (rd_ptr)
`ifdef SCHED_DUP_COUNT_EN
    ,
    .dup_count (dup_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference: each pending spike is keyed by the absolute tick number that delivers it.
  logic [NA-1:0] due_map [int];
  int            tick_cnt;
  logic [NA-1:0] m_spikes;
  logic          m_valid;
  logic          m_err;

  int  checks = 0;
  int  failures = 0;
  bit  cur_t, cur_w, cur_ec;
  int  cur_d, cur_a;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit t, input bit w, input int d, input int a, input bit ec);
    cur_t = t; cur_w = w; cur_d = d; cur_a = a; cur_ec = ec;
    tick       = t;
    bus.wen    = w;
    bus.packet = {DW'(d), AW'(a)};
    error_clr  = ec;
  endtask

  task automatic model_reset();
    due_map.delete();
    tick_cnt = 0;
    m_spikes = '0;
    m_valid  = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_edge();
    int            base;
    int            due;
    logic [NA-1:0] v;
    base = tick_cnt;
    m_valid = cur_t;
    if (cur_t) begin
      tick_cnt++;
      m_spikes = due_map.exists(tick_cnt) ? due_map[tick_cnt] : '0;
      due_map.delete(tick_cnt);
    end
    if (cur_w && cur_a < NA && cur_d < NS) begin
      due = base + (cur_t ? 1 : 0) + cur_d + 1;
      v = due_map.exists(due) ? due_map[due] : '0;
      v[cur_a] = 1'b1;
      due_map[due] = v;
    end
    if (cur_w && !(cur_a < NA && cur_d < NS)) m_err = 1'b1;
    else if (cur_ec)                          m_err = 1'b0;
  endtask

  task automatic compare_all(input string phase);
    chk({phase, ".axon_spikes"}, 256'(bus.axon_spikes), 256'(m_spikes));
    chk({phase, ".spikes_valid"}, 256'(bus.spikes_valid), 256'(m_valid));
    chk({phase, ".error"}, 256'(error), 256'(m_err));
    chk({phase, ".rd_ptr"}, 256'(rd_ptr), 256'(tick_cnt % NS));
  endtask

  task automatic step(input string phase);
    @(posedge clk);
    model_edge();
    #1;
    drive(0, 0, 0, 0, 0);
    compare_all(phase);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0);
    #1;
    compare_all("reset");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step("post_reset");
  endtask

  task automatic do_tick(input string phase);
    drive(1, 0, 0, 0, 0);
    step(phase);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    model_reset();
    #1;
    apply_reset();

    // Basic: delay 0 lands on the next tick only.
    drive(0, 1, 0, 5, 0); step("basic_wr");
    step("basic_idle");
    do_tick("basic_tick");
    step("basic_hold");
    do_tick("basic_next");

    // Delay 3 on the highest legal axon.
    drive(0, 1, 3, NA - 1, 0); step("delay_wr");
    for (int i = 0; i < 4; i++) begin
      do_tick("delay_tick");
      step("delay_hold");
    end

    // Collision at the last slot: set wins over clear, wrap of the pointer.
    while (tick_cnt % NS != NS - 1) do_tick("coll_adv");
    drive(0, 1, 0, 3, 0); step("coll_pre");
    drive(1, 1, NS - 1, 7, 0); step("coll_wr");
    for (int i = 0; i < NS; i++) do_tick("coll_tick");

    // Illegal packets and sticky error.
    drive(0, 1, 0, 250, 0); step("ill_axon");
    for (int i = 0; i < NS; i++) do_tick("ill_tick");
    drive(0, 0, 0, 0, 1); step("ill_clr");
    drive(0, 1, 12, 5, 0); step("ill_delay");
    for (int i = 0; i < NS; i++) do_tick("ill_tick2");
    drive(1, 1, NS, 3, 1); step("ill_clr_set");
    drive(0, 1, 1, 4, 1); step("clr_legal");
    drive(0, 1, 1, 4, 0); step("dup_wr");
    do_tick("dup_t1"); do_tick("dup_t2");

    // Reset mid-run with spikes pending.
    drive(0, 1, 2, 11, 0); step("rst_pend");
    drive(0, 1, 0, 12, 0); step("rst_pend2");
    apply_reset();
    do_tick("rst_tick");

    // Random traffic, mostly legal packets.
    for (int n = 0; n < 1500; n++) begin
      int d, a;
      d = ($urandom % 6 == 0) ? int'($urandom_range(NS, (1 << DW) - 1)) : int'($urandom_range(0, NS - 1));
      a = ($urandom % 8 == 0) ? int'($urandom_range(NA, (1 << AW) - 1)) : int'($urandom_range(0, NA - 1));
      drive(($urandom % 3) == 0, ($urandom % 2) == 0, d, a, ($urandom % 16) == 0);
      step("rand");
    end

    for (int i = 0; i < NS + 1; i++) do_tick("drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
